lsu_stb_state_fifo: RTL and testbench

Parametrised store-buffer state queue for the LSU. It holds per-entry set-index, request-type and RMO bits for ENTRIES outstanding stores, and tracks each entry through three stages: allocate, issue to the PCX, and retire on L2 ack. It replaces the fixed 8-entry per-entry-clock-enable state array with tail, issue and ack pointers, TSO/RMO issue ordering, flush of unissued stores, and a set-index CAM.

---
 rtl/lsu_stb_state_fifo.sv | 122 ++++++++++++
 tb/tb_lsu_stb_state_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stb_state_fifo.sv
// rtl/lsu_stb_state_fifo.sv - store-buffer state queue with tail/issue/ack pointers, TSO/RMO issue and set-index CAM
module lsu_stb_state_fifo #(
  parameter int ENTRIES = 8,
  parameter int PTR_W   = 3,
  parameter int SI_W    = 2,
  parameter int RT_W    = 2
) (
  input  logic               rclk,
  input  logic               arst_l,
  input  logic               wr_vld,
  input  logic [SI_W-1:0]    wr_si,
  input  logic [RT_W-1:0]    wr_rtype,
  input  logic               wr_rmo,
  output logic               wr_rdy,
  output logic               wr_drop,
  output logic               iss_vld,
  input  logic               iss_rdy,
  output logic [PTR_W-1:0]   iss_ptr,
  output logic [SI_W-1:0]    iss_si,
  output logic [RT_W-1:0]    iss_rtype,
  output logic               iss_rmo,
  input  logic               ack_vld,
  output logic               ack_err,
  input  logic               flush,
  input  logic [SI_W-1:0]    cam_si,
  output logic [ENTRIES-1:0] cam_hit,
  output logic [ENTRIES-1:0] ent_vld,
  output logic [ENTRIES-1:0] ent_iss,
  output logic [PTR_W:0]     count,
  output logic               empty
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(ENTRIES);

  logic [PTR_W-1:0]   wptr, iptr, aptr;
  logic [ENTRIES-1:0] vld_q, iss_q, rmo_q;
  logic [SI_W-1:0]    si_q [ENTRIES];
  logic [RT_W-1:0]    rt_q [ENTRIES];
  logic [PTR_W:0]     count_q, count_nxt, flush_cnt;
  logic               drop_q, err_q;
  logic               full, unissued, alloc, iss_fire, ack_ok;

  assign full      = (count_q == CNT_MAX);
  assign wr_rdy    = ~full;
  // Pointer equality is ambiguous when full; the issued bit of the issue slot resolves it.
  assign unissued  = (iptr != wptr) | (full & ~iss_q[iptr]);
  assign iss_vld   = unissued & ~flush & (rmo_q[iptr] | ~(|iss_q));
  assign iss_fire  = iss_vld & iss_rdy;
  assign alloc     = wr_vld & wr_rdy & ~flush;
  assign ack_ok    = ack_vld & iss_q[aptr];

  assign iss_ptr   = iptr;
  assign iss_si    = si_q[iptr];
  assign iss_rtype = rt_q[iptr];
  assign iss_rmo   = rmo_q[iptr];
  assign ent_vld   = vld_q;
  assign ent_iss   = iss_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign wr_drop   = drop_q;
  assign ack_err   = err_q;

  always_comb begin
    flush_cnt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      flush_cnt = flush_cnt + (PTR_W+1)'(vld_q[i] & ~iss_q[i]);
    end
    count_nxt = count_q + (PTR_W+1)'(alloc) - (PTR_W+1)'(ack_ok);
    if (flush) count_nxt = count_nxt - flush_cnt;
  end

  always_comb begin
    cam_hit = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      cam_hit[i] = vld_q[i] & (si_q[i] == cam_si);
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      wptr    <= '0;
      iptr    <= '0;
      aptr    <= '0;
      vld_q   <= '0;
      iss_q   <= '0;
      rmo_q   <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        si_q[i] <= '0;
        rt_q[i] <= '0;
      end
    end else begin
      drop_q  <= wr_vld & ~wr_rdy & ~flush;
      err_q   <= ack_vld & ~iss_q[aptr];
      count_q <= count_nxt;
      if (flush)      wptr <= iptr;
      else if (alloc) wptr <= wptr + PTR_ONE;
      if (iss_fire)   iptr <= iptr + PTR_ONE;
      if (ack_ok)     aptr <= aptr + PTR_ONE;
      // Alloc never targets the ack slot: a free slot at wptr implies it is not issued.
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush && vld_q[i] && !iss_q[i]) vld_q[i] <= 1'b0;
        if (ack_ok && aptr == PTR_W'(i)) begin
          vld_q[i] <= 1'b0;
          iss_q[i] <= 1'b0;
        end
        if (iss_fire && iptr == PTR_W'(i)) iss_q[i] <= 1'b1;
        if (alloc && wptr == PTR_W'(i)) begin
          si_q[i]  <= wr_si;
          rt_q[i]  <= wr_rtype;
          rmo_q[i] <= wr_rmo;
          vld_q[i] <= 1'b1;
          iss_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_stb_state_fifo.sv
// tb/tb_lsu_stb_state_fifo.sv - directed scoreboard bench for lsu_stb_state_fifo
module tb_lsu_stb_state_fifo;

  logic       rclk, arst_l;
  logic       wr_vld, wr_rmo, wr_rdy, wr_drop;
  logic [1:0] wr_si, wr_rtype;
  logic       iss_vld, iss_rdy, iss_rmo;
  logic [2:0] iss_ptr;
  logic [1:0] iss_si, iss_rtype;
  logic       ack_vld, ack_err, flush;
  logic [1:0] cam_si;
  logic [7:0] cam_hit, ent_vld, ent_iss;
  logic [3:0] count;
  logic       empty;

  typedef struct packed {
    logic [2:0] ptr;
    logic [1:0] si;
    logic [1:0] rt;
    logic       rmo;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] tb_wptr;
  int         checks = 0;
  int         errors = 0;

  lsu_stb_state_fifo #(.ENTRIES(8), .PTR_W(3), .SI_W(2), .RT_W(2)) dut (
    .rclk(rclk), .arst_l(arst_l),
    .wr_vld(wr_vld), .wr_si(wr_si), .wr_rtype(wr_rtype), .wr_rmo(wr_rmo),
    .wr_rdy(wr_rdy), .wr_drop(wr_drop),
    .iss_vld(iss_vld), .iss_rdy(iss_rdy), .iss_ptr(iss_ptr), .iss_si(iss_si),
    .iss_rtype(iss_rtype), .iss_rmo(iss_rmo),
    .ack_vld(ack_vld), .ack_err(ack_err), .flush(flush),
    .cam_si(cam_si), .cam_hit(cam_hit),
    .ent_vld(ent_vld), .ent_iss(ent_iss), .count(count), .empty(empty)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue monitor: every accepted issue must match the oldest surviving allocation.
  always @(negedge rclk) begin
    if (arst_l === 1'b1 && iss_vld === 1'b1 && iss_rdy === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected actual ptr %0d expected no issue", iss_ptr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({iss_ptr, iss_si, iss_rtype, iss_rmo} !== e) begin
          errors++;
          $display("FAIL issue_data actual %0h expected %0h",
                   {iss_ptr, iss_si, iss_rtype, iss_rmo}, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    arst_l = 1'b0;
    wr_vld = 1'b0; iss_rdy = 1'b0; ack_vld = 1'b0; flush = 1'b0;
    step();
    arst_l = 1'b1;
    sb.delete();
    tb_wptr = '0;
  endtask

  task automatic alloc(input logic [1:0] si, input logic [1:0] rt, input logic rmo);
    wr_vld = 1'b1; wr_si = si; wr_rtype = rt; wr_rmo = rmo;
    sb.push_back({tb_wptr, si, rt, rmo});
    tb_wptr++;
    step();
    wr_vld = 1'b0;
  endtask

  task automatic issue_ack(input int n);
    for (int k = 0; k < n; k++) begin
      iss_rdy = 1'b1;
      step();
      iss_rdy = 1'b0;
      ack_vld = 1'b1;
      step();
      ack_vld = 1'b0;
    end
  endtask

  initial begin
    wr_si = '0; wr_rtype = '0; wr_rmo = 1'b0; cam_si = '0;
    tb_wptr = '0;
    do_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_wr_rdy", 32'(wr_rdy), 1);
    chk("rst_iss_vld", 32'(iss_vld), 0);
    chk("rst_ent_vld", 32'(ent_vld), 0);
    chk("rst_flags", 32'({wr_drop, ack_err}), 0);

    // Fill to full, then overflow.
    for (int i = 0; i < 8; i++) alloc(2'(i % 4), 2'(3 - i % 4), 1'b0);
    chk("full_count", 32'(count), 8);
    chk("full_wr_rdy", 32'(wr_rdy), 0);
    chk("full_ent_vld", 32'(ent_vld), 32'hff);
    wr_vld = 1'b1;
    step();
    wr_vld = 1'b0;
    chk("drop_pulse", 32'(wr_drop), 1);
    chk("drop_count", 32'(count), 8);
    chk("drop_ent_vld", 32'(ent_vld), 32'hff);
    step();
    chk("drop_clear", 32'(wr_drop), 0);
    chk("full_iss_vld", 32'(iss_vld), 1);
    issue_ack(8);
    chk("drain_empty", 32'(empty), 1);

    // TSO ordering: second store waits for the first ack.
    alloc(1, 0, 0); alloc(2, 1, 0); alloc(3, 2, 0);
    iss_rdy = 1'b1;
    step();
    chk("tso_ent_iss", 32'(ent_iss), 32'h01);
    chk("tso_block", 32'(iss_vld), 0);
    step();
    chk("tso_block2", 32'(iss_vld), 0);
    ack_vld = 1'b1;
    step();
    ack_vld = 1'b0;
    chk("tso_after_ack", 32'(iss_vld), 1);
    chk("tso_after_ack_ptr", 32'(iss_ptr), 1);
    step();
    chk("tso_ent_iss2", 32'(ent_iss), 32'h02);
    iss_rdy = 1'b0;
    ack_vld = 1'b1;
    step();
    ack_vld = 1'b0;
    issue_ack(1);
    chk("tso_empty", 32'(empty), 1);

    // Reset mid-operation discards entries immediately.
    alloc(0, 0, 0); alloc(1, 1, 0);
    arst_l = 1'b0;
    #2;
    chk("async_rst_vld", 32'(ent_vld), 0);
    chk("async_rst_count", 32'(count), 0);
    do_reset();

    // RMO back-to-back issue.
    for (int i = 0; i < 4; i++) alloc(2'(i), 2'(i), 1'b1);
    iss_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("rmo_iss_vld", 32'(iss_vld), 1);
      chk("rmo_iss_ptr", 32'(iss_ptr), k);
      step();
    end
    iss_rdy = 1'b0;
    chk("rmo_done_vld", 32'(iss_vld), 0);
    chk("rmo_ptr4", 32'(iss_ptr), 4);
    chk("rmo_ent_iss", 32'(ent_iss), 32'h0f);
    ack_vld = 1'b1;
    repeat (4) step();
    ack_vld = 1'b0;
    chk("rmo_empty", 32'(empty), 1);

    // Flush with two issued entries and a concurrent allocate.
    do_reset();
    alloc(0, 0, 1); alloc(1, 1, 1); alloc(2, 2, 0); alloc(3, 3, 0); alloc(0, 1, 0);
    iss_rdy = 1'b1;
    step(); step();
    iss_rdy = 1'b0;
    chk("fl_pre_iss", 32'(ent_iss), 32'h03);
    flush = 1'b1; wr_vld = 1'b1; wr_si = 2'd3;
    step();
    flush = 1'b0; wr_vld = 1'b0;
    repeat (3) void'(sb.pop_back());
    tb_wptr = 3'd2;
    chk("fl_ent_vld", 32'(ent_vld), 32'h03);
    chk("fl_iptr", 32'(iss_ptr), 2);
    chk("fl_count", 32'(count), 2);
    chk("fl_no_drop", 32'(wr_drop), 0);
    chk("fl_iss_vld", 32'(iss_vld), 0);
    ack_vld = 1'b1;
    step(); step();
    ack_vld = 1'b0;
    chk("fl_empty", 32'(empty), 1);
    alloc(1, 2, 0);
    chk("fl_wptr2", 32'(ent_vld), 32'h04);
    issue_ack(1);

    // Wrap: 11 single-store round trips.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      alloc(2'(k % 4), 2'(k % 3), 1'b0);
      chk("wrap_count1", 32'(count), 1);
      issue_ack(1);
      chk("wrap_count0", 32'(count), 0);
    end
    chk("wrap_iptr", 32'(iss_ptr), 3);
    alloc(3, 3, 1);
    chk("wrap_wptr", 32'(ent_vld), 32'h08);
    issue_ack(1);

    // CAM and ack error.
    do_reset();
    alloc(2, 0, 0); alloc(1, 1, 0); alloc(2, 2, 0);
    cam_si = 2'd2;
    #1 chk("cam_si2", 32'(cam_hit), 32'h05);
    cam_si = 2'd1;
    #1 chk("cam_si1", 32'(cam_hit), 32'h02);
    cam_si = 2'd2;
    iss_rdy = 1'b1;
    step();
    iss_rdy = 1'b0;
    chk("cam_issued", 32'(cam_hit), 32'h05);
    ack_vld = 1'b1;
    step();
    ack_vld = 1'b0;
    chk("cam_acked", 32'(cam_hit), 32'h04);
    issue_ack(2);
    chk("cam_empty", 32'(empty), 1);
    ack_vld = 1'b1;
    step();
    ack_vld = 1'b0;
    chk("ack_err_pulse", 32'(ack_err), 1);
    step();
    chk("ack_err_clear", 32'(ack_err), 0);
    chk("ack_err_count", 32'(count), 0);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
